frame_rx_sequencer: RTL and testbench

Sequences the receive-side subframe dismantler.
- Hunts for subframe preambles in the raw recovered bitstream and strips them.
- Forwards exactly the 28 payload bits of each subframe (4 aux, 20 data, V, U, C, P) with a valid strobe.
- Generates the per-subframe frame counter (0..191) and channel flag the dismantler needs.
- Tracks block completion and CRC kills, and resynchronises the dismantler on framing loss.

---
 rtl/frame_rx_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_frame_rx_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_rx_sequencer.sv
// frame_rx_sequencer: hunts subframe preambles in the raw bitstream and
// feeds payload bits, frame index and channel flag to the dismantler.
module frame_rx_sequencer #(
   parameter logic [7:0] PRE_B            = 8'hE8,
   parameter logic [7:0] PRE_M            = 8'hE2,
   parameter logic [7:0] PRE_W            = 8'hE4,
   parameter int         PAYLOAD_BITS     = 28,
   parameter int         FRAMES_PER_BLOCK = 192,
   parameter bit         RESYNC_ON_KILL   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vin_raw,
   input  logic        din_raw,
   input  logic        dis_done,
   input  logic        dis_kill,
   output logic        dis_rst,
   output logic        dis_vin,
   output logic        dis_din,
   output logic [7:0]  frame_counter,
   output logic        in_channel,
   output logic        locked,
   output logic        sync_lost,
   output logic [15:0] block_count,
   output logic [15:0] crc_err_count
);

   localparam int BW = $clog2(PAYLOAD_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS - 1);
   localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_BLOCK - 1);

   typedef enum logic [1:0] {
      HUNT,
      PAYLOAD,
      PREAMBLE
   } state_t;

   state_t state, state_nx;

   logic [7:0]    win, win_nx, shifted, pre_exp;
   logic [BW-1:0] bit_cnt, bit_nx;
   logic [2:0]    pre_cnt, pre_nx;
   logic [7:0]    frame_nx;
   logic          chan_nx, locked_nx, vin_nx, din_nx;
   logic          pre_end, pre_ok, kill_loss, loss;

   assign shifted = {win[6:0], din_raw};

   always_comb begin
      pre_exp = PRE_W;
      if (in_channel) begin
         pre_exp = (frame_counter == LAST_FRAME) ? PRE_B : PRE_M;
      end
   end

   assign pre_end   = vin_raw && (state == PREAMBLE) && (pre_cnt == 3'd7);
   assign pre_ok    = (shifted == pre_exp);
   assign kill_loss = dis_kill && RESYNC_ON_KILL;
   // A kill and a preamble mismatch in one cycle merge into one loss event.
   assign loss      = (pre_end && !pre_ok) || kill_loss;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HUNT;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (loss) begin
         state_nx = HUNT;
      end else if (vin_raw) begin
         unique case (state)
            HUNT: begin
               if (shifted == PRE_B) state_nx = PAYLOAD;
            end
            PAYLOAD: begin
               if (bit_cnt == LAST_BIT) state_nx = PREAMBLE;
            end
            PREAMBLE: begin
               if (pre_cnt == 3'd7) state_nx = PAYLOAD;
            end
            default: state_nx = HUNT;
         endcase
      end
   end

   always_comb begin
      win_nx    = win;
      bit_nx    = bit_cnt;
      pre_nx    = pre_cnt;
      frame_nx  = frame_counter;
      chan_nx   = in_channel;
      locked_nx = locked;
      vin_nx    = 1'b0;
      din_nx    = dis_din;
      if (loss) begin
         win_nx    = '0;
         bit_nx    = '0;
         pre_nx    = '0;
         frame_nx  = '0;
         chan_nx   = 1'b0;
         locked_nx = 1'b0;
      end else if (vin_raw) begin
         unique case (state)
            HUNT: begin
               win_nx = shifted;
               if (shifted == PRE_B) begin
                  locked_nx = 1'b1;
                  frame_nx  = '0;
                  chan_nx   = 1'b0;
                  bit_nx    = '0;
               end
            end
            PAYLOAD: begin
               vin_nx = 1'b1;
               din_nx = din_raw;
               pre_nx = '0;
               bit_nx = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
            PREAMBLE: begin
               win_nx = shifted;
               pre_nx = pre_cnt + 3'd1;
               if (pre_cnt == 3'd7) begin
                  if (!in_channel) begin
                     chan_nx = 1'b1;
                  end else begin
                     chan_nx  = 1'b0;
                     frame_nx = (frame_counter == LAST_FRAME) ?
                                8'd0 : frame_counter + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         win           <= '0;
         bit_cnt       <= '0;
         pre_cnt       <= '0;
         frame_counter <= '0;
         in_channel    <= 1'b0;
         locked        <= 1'b0;
         dis_vin       <= 1'b0;
         dis_din       <= 1'b0;
         sync_lost     <= 1'b0;
         dis_rst       <= 1'b1;
      end else begin
         win           <= win_nx;
         bit_cnt       <= bit_nx;
         pre_cnt       <= pre_nx;
         frame_counter <= frame_nx;
         in_channel    <= chan_nx;
         locked        <= locked_nx;
         dis_vin       <= vin_nx;
         dis_din       <= din_nx;
         sync_lost     <= loss;
         dis_rst       <= loss;
      end
   end

   // A simultaneous done and kill is a failed block, never a good one.
   always_ff @(posedge clk) begin
      if (rst) begin
         block_count   <= '0;
         crc_err_count <= '0;
      end else if (dis_kill) begin
         if (crc_err_count != 16'hFFFF) begin
            crc_err_count <= crc_err_count + 16'd1;
         end
      end else if (dis_done) begin
         if (block_count != 16'hFFFF) begin
            block_count <= block_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_frame_rx_sequencer.sv
// tb_frame_rx_sequencer: directed bench for frame_rx_sequencer.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_frame_rx_sequencer;

   logic        clk;
   logic        rst;
   logic        vin_raw;
   logic        din_raw;
   logic        dis_done;
   logic        dis_kill;

   logic        dis_rst, dis_vin, dis_din, in_channel, locked, sync_lost;
   logic [7:0]  frame_counter;
   logic [15:0] block_count, crc_err_count;

   logic        nr_dis_rst, nr_dis_vin, nr_dis_din, nr_chan, nr_locked;
   logic        nr_sync_lost;
   logic [7:0]  nr_frame;
   logic [15:0] nr_blocks, nr_crc;

   int checks = 0;
   int errors = 0;
   int sl_cnt = 0;

   logic       rxq[$];
   logic [7:0] rfc[$];
   logic       rch[$];
   logic       expq[$];
   logic [7:0] efc[$];
   logic       ech[$];

   frame_rx_sequencer dut (
      .clk(clk), .rst(rst), .vin_raw(vin_raw), .din_raw(din_raw),
      .dis_done(dis_done), .dis_kill(dis_kill),
      .dis_rst(dis_rst), .dis_vin(dis_vin), .dis_din(dis_din),
      .frame_counter(frame_counter), .in_channel(in_channel),
      .locked(locked), .sync_lost(sync_lost),
      .block_count(block_count), .crc_err_count(crc_err_count)
   );

   frame_rx_sequencer #(.RESYNC_ON_KILL(1'b0)) dut_nr (
      .clk(clk), .rst(rst), .vin_raw(vin_raw), .din_raw(din_raw),
      .dis_done(dis_done), .dis_kill(dis_kill),
      .dis_rst(nr_dis_rst), .dis_vin(nr_dis_vin), .dis_din(nr_dis_din),
      .frame_counter(nr_frame), .in_channel(nr_chan),
      .locked(nr_locked), .sync_lost(nr_sync_lost),
      .block_count(nr_blocks), .crc_err_count(nr_crc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (dis_vin) begin
         rxq.push_back(dis_din);
         rfc.push_back(frame_counter);
         rch.push_back(in_channel);
      end
      if (sync_lost) sl_cnt++;
   end

   function automatic logic [27:0] pat(input int i);
      return 28'(($unsigned(i) * 32'h9E3779B1) + 32'h0123_4567);
   endfunction

   function automatic int rx_bad();
      int n = 0;
      foreach (expq[i]) begin
         if (i >= rxq.size()) n++;
         else if (rxq[i] !== expq[i] || rfc[i] !== efc[i] ||
                  rch[i] !== ech[i]) n++;
      end
      return n;
   endfunction

   task automatic clear_q();
      rxq.delete(); rfc.delete(); rch.delete();
      expq.delete(); efc.delete(); ech.delete();
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input int gap);
      vin_raw = 1'b1;
      din_raw = b;
      @(negedge clk);
      vin_raw = 1'b0;
      din_raw = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] v, input int gap);
      for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
   endtask

   task automatic send_pay(input logic [27:0] p, input logic [7:0] fc,
                           input logic ch, input int gap);
      for (int i = 27; i >= 0; i--) begin
         send_bit(p[i], gap);
         expq.push_back(p[i]);
         efc.push_back(fc);
         ech.push_back(ch);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; vin_raw = 1'b0; din_raw = 1'b0;
      dis_done = 1'b0; dis_kill = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_q();
      sl_cnt = 0;
   endtask

   // PRE_B and all frames up to frame 191's channel-1 payload.
   task automatic run_block();
      send_byte(8'hE8, 0);
      for (int f = 0; f < 192; f++) begin
         send_pay(pat(2 * f), 8'(f), 1'b0, 0);
         send_byte(8'hE4, 0);
         send_pay(pat(2 * f + 1), 8'(f), 1'b1, 0);
         if (f < 191) send_byte(8'hE2, 0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; vin_raw = 1'b0; din_raw = 1'b0;
      dis_done = 1'b0; dis_kill = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (dis_rst !== 1'b1 || dis_vin !== 1'b0 || locked !== 1'b0 ||
          sync_lost !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl: rst/vin/lock/sl=%b%b%b%b want 1000",
                  dis_rst, dis_vin, locked, sync_lost);
      end
      checks++;
      if (frame_counter !== 8'd0 || in_channel !== 1'b0 ||
          block_count !== 16'd0 || crc_err_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_cnt: fc=%0d ch=%b blk=%0d crc=%0d want 0",
                  frame_counter, in_channel, block_count, crc_err_count);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (dis_rst !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: dis_rst=%b want 0", dis_rst);
      end
   endtask

   task automatic test_basic();
      do_reset();
      send_byte(8'hE8, 0);
      checks++;
      if (locked !== 1'b1 || frame_counter !== 8'd0 || in_channel !== 1'b0) begin
         errors++;
         $display("FAIL basic_lock: lk=%b fc=%0d ch=%b want 1 0 0",
                  locked, frame_counter, in_channel);
      end
      send_pay(pat(100), 8'd0, 1'b0, 0);
      send_byte(8'hE4, 0);
      checks++;
      if (in_channel !== 1'b1 || frame_counter !== 8'd0) begin
         errors++;
         $display("FAIL basic_w: ch=%b fc=%0d want 1 0",
                  in_channel, frame_counter);
      end
      send_pay(pat(101), 8'd0, 1'b1, 0);
      send_byte(8'hE2, 0);
      checks++;
      if (in_channel !== 1'b0 || frame_counter !== 8'd1) begin
         errors++;
         $display("FAIL basic_m: ch=%b fc=%0d want 0 1",
                  in_channel, frame_counter);
      end
      send_pay(pat(102), 8'd1, 1'b0, 0);
      repeat (2) tick();
      checks++;
      if (rxq.size() != 84) begin
         errors++;
         $display("FAIL basic_count: got %0d beats want 84", rxq.size());
      end
      checks++;
      if (rx_bad() != 0) begin
         errors++;
         $display("FAIL basic_data: %0d bad beats want 0", rx_bad());
      end
   endtask

   task automatic test_block();
      do_reset();
      run_block();
      checks++;
      if (frame_counter !== 8'd191 || in_channel !== 1'b1) begin
         errors++;
         $display("FAIL block_last: fc=%0d ch=%b want 191 1",
                  frame_counter, in_channel);
      end
      send_byte(8'hE8, 0);
      checks++;
      if (frame_counter !== 8'd0 || in_channel !== 1'b0 ||
          locked !== 1'b1) begin
         errors++;
         $display("FAIL block_wrap: fc=%0d ch=%b lk=%b want 0 0 1",
                  frame_counter, in_channel, locked);
      end
      dis_done = 1'b1;
      tick();
      dis_done = 1'b0;
      checks++;
      if (block_count !== 16'd1 || crc_err_count !== 16'd0) begin
         errors++;
         $display("FAIL block_done: blk=%0d crc=%0d want 1 0",
                  block_count, crc_err_count);
      end
      checks++;
      if (sl_cnt != 0 || rxq.size() != 10752 || rx_bad() != 0) begin
         errors++;
         $display("FAIL block_stream: sl=%0d beats=%0d bad=%0d want 0 10752 0",
                  sl_cnt, rxq.size(), rx_bad());
      end
   endtask

   task automatic test_mismatch();
      do_reset();
      run_block();
      send_byte(8'hE2, 0);
      checks++;
      if (sync_lost !== 1'b1 || dis_rst !== 1'b1 || locked !== 1'b0 ||
          frame_counter !== 8'd0 || in_channel !== 1'b0) begin
         errors++;
         $display("FAIL mis_loss: sl=%b drst=%b lk=%b fc=%0d ch=%b want 1 1 0 0 0",
                  sync_lost, dis_rst, locked, frame_counter, in_channel);
      end
      tick();
      checks++;
      if (sync_lost !== 1'b0 || dis_rst !== 1'b0) begin
         errors++;
         $display("FAIL mis_pulse: sl=%b drst=%b want 0 0", sync_lost, dis_rst);
      end
      clear_q();
      for (int i = 0; i < 20; i++) send_bit(1'b0, 0);
      send_byte(8'hE8, 0);
      checks++;
      if (rxq.size() != 0 || locked !== 1'b1) begin
         errors++;
         $display("FAIL mis_relock: beats=%0d lk=%b want 0 1",
                  rxq.size(), locked);
      end
      send_pay(pat(7), 8'd0, 1'b0, 0);
      tick();
      checks++;
      if (rxq.size() != 28 || rx_bad() != 0 || sl_cnt != 1) begin
         errors++;
         $display("FAIL mis_after: beats=%0d bad=%0d sl=%0d want 28 0 1",
                  rxq.size(), rx_bad(), sl_cnt);
      end
   endtask

   task automatic test_kill();
      logic [7:0] m;
      do_reset();
      send_byte(8'hE8, 0);
      for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
      dis_kill = 1'b1;
      tick();
      dis_kill = 1'b0;
      checks++;
      if (sync_lost !== 1'b1 || dis_rst !== 1'b1 || locked !== 1'b0 ||
          crc_err_count !== 16'd1) begin
         errors++;
         $display("FAIL kill_resync: sl=%b drst=%b lk=%b crc=%0d want 1 1 0 1",
                  sync_lost, dis_rst, locked, crc_err_count);
      end
      checks++;
      if (nr_locked !== 1'b1 || nr_sync_lost !== 1'b0 ||
          nr_dis_rst !== 1'b0 || nr_crc !== 16'd1) begin
         errors++;
         $display("FAIL kill_noresync: lk=%b sl=%b drst=%b crc=%0d want 1 0 0 1",
                  nr_locked, nr_sync_lost, nr_dis_rst, nr_crc);
      end
      dis_kill = 1'b1;
      dis_done = 1'b1;
      tick();
      dis_kill = 1'b0;
      dis_done = 1'b0;
      checks++;
      if (block_count !== 16'd0 || crc_err_count !== 16'd2 ||
          nr_blocks !== 16'd0 || nr_crc !== 16'd2) begin
         errors++;
         $display("FAIL kill_done: blk=%0d crc=%0d nr=%0d/%0d want 0 2 0/2",
                  block_count, crc_err_count, nr_blocks, nr_crc);
      end
      do_reset();
      send_byte(8'hE8, 0);
      send_pay(pat(3), 8'd0, 1'b0, 0);
      m = 8'hE2;
      for (int i = 7; i >= 1; i--) send_bit(m[i], 0);
      dis_kill = 1'b1;
      send_bit(m[0], 0);
      dis_kill = 1'b0;
      repeat (2) tick();
      checks++;
      if (sl_cnt != 1 || crc_err_count !== 16'd1 || locked !== 1'b0) begin
         errors++;
         $display("FAIL kill_merge: sl=%0d crc=%0d lk=%b want 1 1 0",
                  sl_cnt, crc_err_count, locked);
      end
   endtask

   task automatic test_gaps();
      logic [27:0] p;
      do_reset();
      send_byte(8'hE8, 0);
      p = pat(100);
      for (int i = 27; i >= 0; i--) begin
         send_bit(p[i], 1);
         expq.push_back(p[i]);
         efc.push_back(8'd0);
         ech.push_back(1'b0);
         if (i == 14) begin
            checks++;
            if (frame_counter !== 8'd0 || in_channel !== 1'b0 ||
                locked !== 1'b1) begin
               errors++;
               $display("FAIL gap_mid: fc=%0d ch=%b lk=%b want 0 0 1",
                        frame_counter, in_channel, locked);
            end
         end
      end
      send_byte(8'hE4, 1);
      checks++;
      if (rxq.size() != 28 || rx_bad() != 0 || in_channel !== 1'b1) begin
         errors++;
         $display("FAIL gap_stream: beats=%0d bad=%0d ch=%b want 28 0 1",
                  rxq.size(), rx_bad(), in_channel);
      end
   endtask

   task automatic test_rst_mid();
      logic [27:0] p;
      do_reset();
      send_byte(8'hE8, 0);
      p = pat(55);
      for (int i = 27; i >= 15; i--) send_bit(p[i], 0);
      rst = 1'b1;
      vin_raw = 1'b1;
      din_raw = p[14];
      tick();
      rst = 1'b0;
      vin_raw = 1'b0;
      clear_q();
      for (int i = 0; i < 30; i++) send_bit(1'b1, 0);
      checks++;
      if (rxq.size() != 0 || locked !== 1'b0) begin
         errors++;
         $display("FAIL rst_trash: beats=%0d lk=%b want 0 0",
                  rxq.size(), locked);
      end
      send_byte(8'hE8, 0);
      send_pay(pat(56), 8'd0, 1'b0, 0);
      tick();
      checks++;
      if (rxq.size() != 28 || rx_bad() != 0) begin
         errors++;
         $display("FAIL rst_clean: beats=%0d bad=%0d want 28 0",
                  rxq.size(), rx_bad());
      end
   endtask

   task automatic test_saturation();
      do_reset();
      force dut.block_count = 16'hFFFF;
      force dut.crc_err_count = 16'hFFFF;
      tick();
      release dut.block_count;
      release dut.crc_err_count;
      tick();
      dis_done = 1'b1;
      tick();
      dis_done = 1'b0;
      checks++;
      if (block_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_block: blk=%h want ffff", block_count);
      end
      dis_kill = 1'b1;
      tick();
      dis_kill = 1'b0;
      checks++;
      if (crc_err_count !== 16'hFFFF || block_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_crc: crc=%h blk=%h want ffff ffff",
                  crc_err_count, block_count);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_block();
      test_mismatch();
      test_kill();
      test_gaps();
      test_rst_mid();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
